// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions.
// Writeback entry layout and register-file constants.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int ZERO_REG   = 0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/reg_write_fifo.sv
// Dual-push / single-pop circular writeback queue.
// Exposes its entries oldest-first for the bypass search.
module reg_write_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int CW     = $clog2(DEPTH+1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_push0,
  input  logic [ADDR_W-1:0]              i_reg0,
  input  logic [DATA_W-1:0]              i_data0,
  input  logic                           i_push1,
  input  logic [ADDR_W-1:0]              i_reg1,
  input  logic [DATA_W-1:0]              i_data1,
  input  logic                           i_pop,
  output logic [ADDR_W-1:0]              o_head_reg,
  output logic [DATA_W-1:0]              o_head_data,
  output logic [CW-1:0]                  o_count,
  output logic [DEPTH-1:0]               o_vis,
  output logic [DEPTH-1:0][ADDR_W-1:0]   o_vis_reg,
  output logic [DEPTH-1:0][DATA_W-1:0]   o_vis_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [ADDR_W-1:0] r_reg  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  logic [PW-1:0]     w_wp1;
  logic [PW-1:0]     w_wp_alu;
  logic [PW-1:0]     w_wptr_nxt;
  logic [PW-1:0]     w_rptr_nxt;
  logic [1:0]        w_npush;
  logic [CW-1:0]     w_count_nxt;

  // Operands never exceed 2*DEPTH-1, so one subtraction wraps.
  function automatic logic [PW-1:0] wrap(input int v);
    return (v >= DEPTH) ? PW'(v - DEPTH) : PW'(v);
  endfunction

  always_comb begin
    w_npush     = {1'b0, i_push0} + {1'b0, i_push1};
    w_wp1       = wrap(int'(r_wptr) + 1);
    w_wp_alu    = i_push0 ? w_wp1 : r_wptr;
    w_wptr_nxt  = wrap(int'(r_wptr) + int'(w_npush));
    w_rptr_nxt  = i_pop ? wrap(int'(r_rptr) + 1) : r_rptr;
    w_count_nxt = r_count + CW'(w_npush) - CW'(i_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push0) begin
      r_reg[r_wptr]  <= i_reg0;
      r_data[r_wptr] <= i_data0;
    end
    if (i_push1) begin
      r_reg[w_wp_alu]  <= i_reg1;
      r_data[w_wp_alu] <= i_data1;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      o_vis[k]      = CW'(k) < r_count;
      o_vis_reg[k]  = r_reg[wrap(int'(r_rptr) + k)];
      o_vis_data[k] = r_data[wrap(int'(r_rptr) + k)];
    end
  end

  assign o_head_reg  = r_reg[r_rptr];
  assign o_head_data = r_data[r_rptr];
  assign o_count     = r_count;

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write initiator: queues ALU and load results,
// issues one write per cycle and offers a bypass lookup.
module reg_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         memValid,
  input  logic [ADDR_W-1:0]            memReg,
  input  logic [DATA_W-1:0]            memData,
  output logic                         memReady,
  input  logic                         aluValid,
  input  logic [ADDR_W-1:0]            aluReg,
  input  logic [DATA_W-1:0]            aluData,
  output logic                         aluReady,
  output logic                         regWriteCtrl,
  output logic [ADDR_W-1:0]            writeRegister,
  output logic [DATA_W-1:0]            writeData,
  input  logic [ADDR_W-1:0]            bypassReg,
  output logic                         bypassHit,
  output logic [DATA_W-1:0]            bypassData,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  logic                           w_push_mem;
  logic                           w_push_alu;
  logic                           w_pop;
  logic [ADDR_W-1:0]              w_head_reg;
  logic [DATA_W-1:0]              w_head_data;
  logic [CW-1:0]                  w_count;
  logic [DEPTH-1:0]               w_vis;
  logic [DEPTH-1:0][ADDR_W-1:0]   w_vis_reg;
  logic [DEPTH-1:0][DATA_W-1:0]   w_vis_data;

  logic                           r_we;
  logic [ADDR_W-1:0]              r_wreg;
  logic [DATA_W-1:0]              r_wdata;

  // Readiness looks only at registered occupancy, never at the pop.
  assign memReady = w_count <= CW'(DEPTH-1);
  assign aluReady = w_count <= CW'(DEPTH-2);

  assign w_push_mem = memValid & memReady & (memReg != ADDR_W'(ZERO_REG));
  assign w_push_alu = aluValid & aluReady & (aluReg != ADDR_W'(ZERO_REG));
  assign w_pop      = w_count != '0;

  reg_write_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .CW     (CW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push0     (w_push_mem),
    .i_reg0      (memReg),
    .i_data0     (memData),
    .i_push1     (w_push_alu),
    .i_reg1      (aluReg),
    .i_data1     (aluData),
    .i_pop       (w_pop),
    .o_head_reg  (w_head_reg),
    .o_head_data (w_head_data),
    .o_count     (w_count),
    .o_vis       (w_vis),
    .o_vis_reg   (w_vis_reg),
    .o_vis_data  (w_vis_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (w_pop) begin
      r_we    <= 1'b1;
      r_wreg  <= w_head_reg;
      r_wdata <= w_head_data;
    end else begin
      r_we    <= 1'b0;
    end
  end

  // Oldest first so younger matches overwrite older ones.
  always_comb begin
    bypassHit  = 1'b0;
    bypassData = '0;
    if (bypassReg != ADDR_W'(ZERO_REG)) begin
      if (r_we && r_wreg == bypassReg) begin
        bypassHit  = 1'b1;
        bypassData = r_wdata;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if (w_vis[k] && w_vis_reg[k] == bypassReg) begin
          bypassHit  = 1'b1;
          bypassData = w_vis_data[k];
        end
      end
    end
  end

  assign regWriteCtrl  = r_we;
  assign writeRegister = r_wreg;
  assign writeData     = r_wdata;
  assign count         = w_count;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter.
// Hand-computed expectations for queueing, ordering, bypass and reset.
module tb_reg_write_arbiter;

  logic        clk;
  logic        rst;
  logic        memValid;
  logic [4:0]  memReg;
  logic [31:0] memData;
  logic        memReady;
  logic        aluValid;
  logic [4:0]  aluReg;
  logic [31:0] aluData;
  logic        aluReady;
  logic        regWriteCtrl;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [4:0]  bypassReg;
  logic        bypassHit;
  logic [31:0] bypassData;
  logic [2:0]  count;

  int n_chk;
  int n_pass;
  bit rec;
  logic [36:0] commits [$];

  reg_write_arbiter #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .memValid      (memValid),
    .memReg        (memReg),
    .memData       (memData),
    .memReady      (memReady),
    .aluValid      (aluValid),
    .aluReg        (aluReg),
    .aluData       (aluData),
    .aluReady      (aluReady),
    .regWriteCtrl  (regWriteCtrl),
    .writeRegister (writeRegister),
    .writeData     (writeData),
    .bypassReg     (bypassReg),
    .bypassHit     (bypassHit),
    .bypassData    (bypassData),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rec && regWriteCtrl)
      commits.push_back({writeRegister, writeData});
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memValid = 1'b0;
    memReg   = '0;
    memData  = '0;
    aluValid = 1'b0;
    aluReg   = '0;
    aluData  = '0;
  endtask

  initial begin
    logic [2:0]  exp_cnt [6];
    logic        exp_ar  [6];
    logic [4:0]  exp_r   [8];
    logic [31:0] exp_d   [8];
    int mi;
    int ai;
    exp_cnt = '{3'd0, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3};
    exp_ar  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_r   = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd14, 5'd16, 5'd18};
    exp_d   = '{32'hA0, 32'hB0, 32'hA1, 32'hB1,
                32'hA2, 32'hA3, 32'hA4, 32'hA5};
    n_chk = 0;
    n_pass = 0;
    rec = 1'b0;
    rst = 1'b1;
    bypassReg = 5'd3;
    idle_inputs();

    // reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("rst_we",    regWriteCtrl, 1'b0);
    chk("rst_mrdy",  memReady, 1'b1);
    chk("rst_ardy",  aluReady, 1'b1);
    chk("rst_cnt",   count, 3'd0);
    chk("rst_hit",   bypassHit, 1'b0);
    chk("rst_bdata", bypassData, 32'h0);

    // same-cycle MEM and ALU to r3
    memValid = 1'b1; memReg = 5'd3; memData = 32'h11;
    aluValid = 1'b1; aluReg = 5'd3; aluData = 32'h22;
    step();
    idle_inputs();
    #1;
    chk("r3_cnt2",  count, 3'd2);
    chk("r3_we0",   regWriteCtrl, 1'b0);
    chk("r3_hit0",  bypassHit, 1'b1);
    chk("r3_byp0",  bypassData, 32'h22);
    step();
    chk("r3_we1",   regWriteCtrl, 1'b1);
    chk("r3_wr1",   writeRegister, 5'd3);
    chk("r3_wd1",   writeData, 32'h11);
    chk("r3_cnt1",  count, 3'd1);
    chk("r3_byp1",  bypassData, 32'h22);
    step();
    chk("r3_we2",   regWriteCtrl, 1'b1);
    chk("r3_wd2",   writeData, 32'h22);
    chk("r3_cnt3",  count, 3'd0);
    chk("r3_hit2",  bypassHit, 1'b1);
    chk("r3_byp2",  bypassData, 32'h22);
    step();
    chk("r3_we3",   regWriteCtrl, 1'b0);
    chk("r3_hit3",  bypassHit, 1'b0);
    chk("r3_byp3",  bypassData, 32'h0);
    chk("r3_hold",  writeData, 32'h22);

    // write to r0 is swallowed
    aluValid = 1'b1; aluReg = 5'd0; aluData = 32'hFFFF_FFFF;
    bypassReg = 5'd0;
    #1;
    chk("r0_ardy",  aluReady, 1'b1);
    step();
    idle_inputs();
    chk("r0_cnt",   count, 3'd0);
    chk("r0_hit",   bypassHit, 1'b0);
    chk("r0_bdata", bypassData, 32'h0);
    step();
    chk("r0_we",    regWriteCtrl, 1'b0);

    // dual pushes every cycle with backpressure
    bypassReg = 5'd30;
    commits.delete();
    rec = 1'b1;
    mi = 0;
    ai = 0;
    for (int c = 0; c < 6; c++) begin
      memValid = 1'b1; memReg = 5'(8 + 2*mi); memData = 32'hA0 + 32'(mi);
      aluValid = 1'b1; aluReg = 5'(9 + 2*ai); aluData = 32'hB0 + 32'(ai);
      #1;
      chk($sformatf("dual_cnt%0d", c),  count, exp_cnt[c]);
      chk($sformatf("dual_mrdy%0d", c), memReady, 1'b1);
      chk($sformatf("dual_ardy%0d", c), aluReady, exp_ar[c]);
      if (memReady) mi++;
      if (aluReady) ai++;
      step();
    end
    idle_inputs();
    repeat (6) step();
    rec = 1'b0;
    chk("dual_cnt_end", count, 3'd0);
    chk("dual_ncommit", commits.size(), 8);
    for (int i = 0; i < 8 && i < commits.size(); i++) begin
      chk($sformatf("dual_reg%0d", i),  commits[i][36:32], exp_r[i]);
      chk($sformatf("dual_data%0d", i), commits[i][31:0],  exp_d[i]);
    end

    // fill, then reset mid-cycle
    memValid = 1'b1; memReg = 5'd20; memData = 32'h200;
    aluValid = 1'b1; aluReg = 5'd21; aluData = 32'h201;
    step();
    memReg = 5'd22; memData = 32'h202;
    aluReg = 5'd23; aluData = 32'h203;
    step();
    idle_inputs();
    chk("mrst_cnt3", count, 3'd3);
    chk("mrst_we1",  regWriteCtrl, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_we",   regWriteCtrl, 1'b0);
    chk("mrst_cnt",  count, 3'd0);
    chk("mrst_wr",   writeRegister, 5'd0);
    chk("mrst_wd",   writeData, 32'h0);
    chk("mrst_mrdy", memReady, 1'b1);
    chk("mrst_ardy", aluReady, 1'b1);
    commits.delete();
    rec = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    rec = 1'b0;
    chk("mrst_nowr", commits.size(), 0);
    chk("mrst_cnt_after", count, 3'd0);

    // single all-ones write to r5
    bypassReg = 5'd5;
    memValid = 1'b1; memReg = 5'd5; memData = 32'hFFFF_FFFF;
    step();
    idle_inputs();
    #1;
    chk("r5_cnt",   count, 3'd1);
    chk("r5_qhit",  bypassHit, 1'b1);
    chk("r5_qdata", bypassData, 32'hFFFF_FFFF);
    step();
    chk("r5_we",    regWriteCtrl, 1'b1);
    chk("r5_wr",    writeRegister, 5'd5);
    chk("r5_wd",    writeData, 32'hFFFF_FFFF);
    chk("r5_hit",   bypassHit, 1'b1);
    step();
    chk("r5_we_off", regWriteCtrl, 1'b0);
    chk("r5_miss",  bypassHit, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Register-file write-side initiator for the pipelined MIPS datapath: it accepts writeback results from the ALU path and the load (MEM) path, buffers them in an in-order queue, and drives exactly one write per cycle onto the register file's `regWriteCtrl` / `writeRegister` / `writeData` port. It also exposes a bypass lookup so decode can read values that are queued but not yet committed. It sits between the WB stage and the register file and replaces direct WB-to-register-file wiring.

## Interface
- `DEPTH`, 4: queue entries (≥2).
- `DATA_W`, 32: data width.
- `ADDR_W`, 5: register index width.
- Clock and reset: one clock; reset is asynchronous and active-high.

- `clk`  in  1  clock, all state on posedge.
- `rst`  in  1  asynchronous active-high reset.
- `memValid`  in  1  load result offered.
- `memReg`  in  ADDR_W  load destination.
- `memData`  in  DATA_W  load value.
- `memReady`  out  1  load result accepted when `memValid & memReady`.
- `aluValid`  in  1  ALU result offered.
- `aluReg`  in  ADDR_W  ALU destination.
- `aluData`  in  DATA_W  ALU value.
- `aluReady`  out  1  ALU result accepted when `aluValid & aluReady`.
- `regWriteCtrl`  out  1  register-file write enable (registered).
- `writeRegister`  out  ADDR_W  register-file write index (registered).
- `writeData`  out  DATA_W  register-file write data (registered).
- `bypassReg`  in  ADDR_W  register index decode wants.
- `bypassHit`  out  1  a pending (uncommitted) write to `bypassReg` exists.
- `bypassData`  out  DATA_W  value of the youngest pending write to `bypassReg`.
- `count`  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- Queue: circular buffer of DEPTH entries {reg, data}; read/write pointers wrap modulo DEPTH; `count` 0..DEPTH.
- Readiness (from registered `count` only, independent of valids and same-cycle pop): `memReady = count ≤ DEPTH-1`; `aluReady = count ≤ DEPTH-2`.
- Push order within one cycle: MEM entry first (older), then ALU entry.
- Writes to register 0 are accepted (handshake completes) but never enqueued and never raise `bypassHit`.
- Pop: every cycle with `count > 0`, head entry loads the output register: `regWriteCtrl=1`, `writeRegister`/`writeData` = head. With `count == 0`, `regWriteCtrl=0`; `writeRegister`/`writeData` hold previous values.
- Simultaneous push(es) and pop: `count_next = count + pushes - pop`; never exceeds DEPTH by construction of readiness.
- Bypass (combinational): search all valid queue entries plus the output register while `regWriteCtrl=1`; youngest match wins (newest queue entry > older entries > output register). `bypassReg == 0` → `bypassHit=0`, `bypassData=0`. No match → `bypassHit=0`, `bypassData=0`. Same-cycle inputs are not searched.

## Timing
- Reset (async, immediate): `count=0`, pointers 0, `regWriteCtrl=0`, `writeRegister=0`, `writeData=0`; hence `memReady=1`, `aluReady=1`, `bypassHit=0`, `bypassData=0`. Reset mid-operation discards all pending entries.
- Latency: accepted at posedge N → enqueued after N → driven on write port after posedge N+1 (if at head) → committed by register file at the following negedge. Queue-empty push-to-commit = 1.5 cycles.
- Outputs change only on posedge, so they are stable at the register file's negedge write.
- Throughput: one commit per cycle; two accepts per cycle sustainable only while `count ≤ DEPTH-2`.
- Ordering: commits occur in strict acceptance order; same-register writes commit oldest first.

## Structure
- Shared package `mips_pkg`: `REG_ADDR_W=5`, `DATA_W=32`, `ZERO_REG=0`, writeback entry type {reg, data}.
- Sub-module `reg_write_fifo`: dual-push/single-pop circular buffer with `count` and per-entry visibility for the bypass search; top level holds readiness, output register, and bypass priority logic.

## Test plan
- Reset then idle → `regWriteCtrl=0`, `memReady=aluReady=1`, `count=0`, `bypassHit=0`.
- Same-cycle push MEM{r3,0x11} and ALU{r3,0x22} → commits r3=0x11 then r3=0x22 on consecutive cycles; `bypassReg=3` returns 0x22 until second commit.
- ALU{r0,0xFFFFFFFF} accepted → `count` unchanged, no write issued, `bypassReg=0` → miss.
- Dual pushes every cycle, DEPTH=4 → `aluReady` drops at `count=3`, `memReady` drops at `count=4`, no loss, all entries commit in order after valids drop.
- Fill to 3 entries, assert `rst` mid-cycle → outputs reset immediately, no further writes, `count=0`.
- Push r5=0xFFFFFFFF into empty queue → `regWriteCtrl=1`, `writeRegister=5` exactly one cycle, `bypassHit=1` during that cycle.
